// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-engine state encoding.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Width of the read/write latency counters; latencies are at most 15.
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axil_rd_fifo.sv
// In-order read response queue; each entry carries a countdown that gates the
// head from being presented until its latency has elapsed.
module axil_rd_fifo
  import axil_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_ready,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             push_en;
  logic             pop_en;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [LAT_W-1:0] cnt_reg  [DEPTH];

  assign wr_idx  = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx  = rd_ptr_reg[PTR_W-1:0];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == rd_idx);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign head_data  = data_mem[rd_idx];
  assign head_ready = (cnt_reg[rd_idx] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) data_mem[wr_idx] <= push_data;
  end

  // The push cycle itself counts as the first latency cycle, so load LAT-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_en && (wr_idx == PTR_W'(i))) begin
          cnt_reg[i] <= LAT_W'(LAT - 1);
        end else if (cnt_reg[i] != '0) begin
          cnt_reg[i] <= cnt_reg[i] - LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: buffered write engine with programmable latency and
// a pipelined, in-order read path with programmable latency and depth.
module axil_mem_slave
  import axil_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RD_LAT    = 2,
  parameter int                WR_LAT    = 1,
  parameter int                RD_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_awvalid,
  output logic                mem_awready,
  input  logic [ADDR_W-1:0]   mem_awaddr,
  input  logic                mem_wvalid,
  output logic                mem_wready,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_bvalid,
  input  logic                mem_bready,
  output logic [1:0]          mem_bresp,
  input  logic                mem_arvalid,
  output logic                mem_arready,
  input  logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_rvalid,
  input  logic                mem_rready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          mem_rresp
);

  localparam int                STRB_W      = DATA_W / 8;
  localparam int                OFF_BITS    = $clog2(STRB_W);
  localparam int                IDX_W       = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);
  localparam int                RD_ENTRY_W  = DATA_W + 2;

  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) >> OFF_BITS;
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Holds the readies low until the first edge after reset is released.
  logic ready_en_reg;

  // ---------------- write path ----------------
  logic              aw_full_reg;
  logic              w_full_reg;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic [STRB_W-1:0] w_strb_reg;
  logic [1:0]        bresp_reg;
  wr_state_t         wr_state_reg;
  wr_state_t         wr_state_next;
  logic [LAT_W-1:0]  wr_cnt_reg;
  logic [LAT_W-1:0]  wr_cnt_next;
  logic              wr_commit;
  logic              aw_hit;
  logic              w_hit;
  logic [ADDR_W-1:0] aw_idx;
  logic              aw_ok;
  logic [DATA_W-1:0] wmask;

  assign mem_awready = ready_en_reg && !aw_full_reg;
  assign mem_wready  = ready_en_reg && !w_full_reg;
  assign aw_hit      = mem_awvalid && mem_awready;
  assign w_hit       = mem_wvalid && mem_wready;
  assign aw_idx      = word_index(aw_addr_reg);
  assign aw_ok       = (aw_addr_reg >= BASE_ADDR) && (aw_idx < MEM_WORDS_A);
  assign mem_bvalid  = (wr_state_reg == W_RESP);
  assign mem_bresp   = bresp_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{w_strb_reg[gi]}};
    end
  endgenerate

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_cnt_next   = wr_cnt_reg;
    wr_commit     = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        if (aw_full_reg && w_full_reg) begin
          if (WR_LAT == 0) begin
            wr_state_next = W_RESP;
            wr_commit     = 1'b1;
          end else begin
            wr_state_next = W_WAIT;
            wr_cnt_next   = LAT_W'(WR_LAT - 1);
          end
        end
      end
      W_WAIT: begin
        if (wr_cnt_reg == '0) begin
          wr_state_next = W_RESP;
          wr_commit     = 1'b1;
        end else begin
          wr_cnt_next = wr_cnt_reg - LAT_W'(1);
        end
      end
      W_RESP: begin
        if (mem_bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_reg <= 1'b0;
      aw_full_reg  <= 1'b0;
      w_full_reg   <= 1'b0;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bresp_reg    <= OKAY;
      wr_state_reg <= W_IDLE;
      wr_cnt_reg   <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      wr_state_reg <= wr_state_next;
      wr_cnt_reg   <= wr_cnt_next;
      // Commit only happens with both buffers full, so it never races a fill.
      if (wr_commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bresp_reg   <= aw_ok ? OKAY : DECERR;
      end
      if (aw_hit) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= mem_awaddr;
      end
      if (w_hit) begin
        w_full_reg <= 1'b1;
        w_data_reg <= mem_wdata;
        w_strb_reg <= mem_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit && aw_ok) begin
      mem[aw_idx[IDX_W-1:0]] <= (mem[aw_idx[IDX_W-1:0]] & ~wmask) | (w_data_reg & wmask);
    end
  end

  // ---------------- read path ----------------
  logic [ADDR_W-1:0]     ar_idx;
  logic                  ar_ok;
  logic [DATA_W-1:0]     ar_word;
  logic                  ar_hit;
  logic [RD_ENTRY_W-1:0] ar_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_ready;
  logic [RD_ENTRY_W-1:0] head_data;
  logic                  rd_pop;

  assign ar_idx   = word_index(mem_araddr);
  assign ar_ok    = (mem_araddr >= BASE_ADDR) && (ar_idx < MEM_WORDS_A);
  // Sampled before any same-edge write lands, so a concurrent commit stays invisible.
  assign ar_word  = ar_ok ? mem[ar_idx[IDX_W-1:0]] : '0;
  assign ar_entry = {(ar_ok ? OKAY : DECERR), ar_word};

  assign mem_arready = ready_en_reg && !fifo_full;
  assign ar_hit      = mem_arvalid && mem_arready;
  assign mem_rvalid  = !fifo_empty && head_ready;
  assign rd_pop      = mem_rvalid && mem_rready;
  assign mem_rdata   = mem_rvalid ? head_data[DATA_W-1:0] : '0;
  assign mem_rresp   = mem_rvalid ? head_data[RD_ENTRY_W-1:DATA_W] : OKAY;

  axil_rd_fifo #(
    .WIDTH (RD_ENTRY_W),
    .DEPTH (RD_DEPTH),
    .LAT   (RD_LAT)
  ) u_rd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (ar_hit),
    .push_data  (ar_entry),
    .pop        (rd_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_ready (head_ready),
    .head_data  (head_data)
  );

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench for axil_mem_slave with default parameters (32-bit, RD_LAT=2, WR_LAT=1, RD_DEPTH=4).
module tb_axil_mem_slave;
  import axil_pkg::*;

  localparam int TIMEOUT = 50;

  logic        clk;
  logic        rst;
  logic        mem_awvalid, mem_awready;
  logic [31:0] mem_awaddr;
  logic        mem_wvalid, mem_wready;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_bvalid, mem_bready;
  logic [1:0]  mem_bresp;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid, mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] a_tab [4];
  logic [31:0] d_tab [4];

  axil_mem_slave dut (
    .clk         (clk),
    .rst         (rst),
    .mem_awvalid (mem_awvalid),
    .mem_awready (mem_awready),
    .mem_awaddr  (mem_awaddr),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_bvalid  (mem_bvalid),
    .mem_bready  (mem_bready),
    .mem_bresp   (mem_bresp),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_araddr  (mem_araddr),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    mem_wvalid = 1'b1; mem_wdata = data; mem_wstrb = strb;
    while (!mem_wready && n < TIMEOUT) begin tick(); n++; end
    check("w_handshake", mem_wready, 1);
    tick();
    mem_wvalid = 1'b0;
    $display("W   data=%h strb=%h", data, strb);
  endtask

  task automatic send_aw(input logic [31:0] addr);
    int n = 0;
    mem_awvalid = 1'b1; mem_awaddr = addr;
    while (!mem_awready && n < TIMEOUT) begin tick(); n++; end
    check("aw_handshake", mem_awready, 1);
    tick();
    mem_awvalid = 1'b0;
    $display("AW  addr=%h", addr);
  endtask

  task automatic send_aww(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    mem_awvalid = 1'b1; mem_awaddr = addr;
    mem_wvalid  = 1'b1; mem_wdata  = data; mem_wstrb = strb;
    while (!(mem_awready && mem_wready) && n < TIMEOUT) begin tick(); n++; end
    check("aww_handshake", mem_awready && mem_wready, 1);
    tick();
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    $display("AW+W addr=%h data=%h strb=%h", addr, data, strb);
  endtask

  task automatic get_b(input logic [1:0] exp_resp);
    int n = 0;
    mem_bready = 1'b1;
    while (!mem_bvalid && n < TIMEOUT) begin tick(); n++; end
    check("bvalid", mem_bvalid, 1);
    check("bresp", mem_bresp, exp_resp);
    tick();
    mem_bready = 1'b0;
    check("bvalid_drop", mem_bvalid, 0);
    $display("B   resp=%0d", mem_bresp);
  endtask

  task automatic read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n = 0;
    mem_arvalid = 1'b1; mem_araddr = addr;
    while (!mem_arready && n < TIMEOUT) begin tick(); n++; end
    check("ar_handshake", mem_arready, 1);
    tick();
    mem_arvalid = 1'b0;
    mem_rready  = 1'b1;
    n = 0;
    while (!mem_rvalid && n < TIMEOUT) begin tick(); n++; end
    check("rvalid", mem_rvalid, 1);
    check($sformatf("rdata@%h", addr), mem_rdata, exp_data);
    check($sformatf("rresp@%h", addr), mem_rresp, exp_resp);
    $display("R   addr=%h data=%h resp=%0d", addr, mem_rdata, mem_rresp);
    tick();
    mem_rready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    mem_awvalid = 0; mem_awaddr = '0; mem_wvalid = 0; mem_wdata = '0; mem_wstrb = '0;
    mem_bready = 0; mem_arvalid = 0; mem_araddr = '0; mem_rready = 0;
    a_tab[0] = 32'h8000_0010; d_tab[0] = 32'hDEAD_BEEF;
    a_tab[1] = 32'h8000_0020; d_tab[1] = 32'h11BB_33DD;
    a_tab[2] = 32'h8000_0030; d_tab[2] = 32'hCAFE_0030;
    a_tab[3] = 32'h8000_0040; d_tab[3] = 32'h0BAD_0040;

    // Reset state
    repeat (2) tick();
    check("rst_bvalid", mem_bvalid, 0);
    check("rst_rvalid", mem_rvalid, 0);
    check("rst_awready", mem_awready, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_bresp", mem_bresp, 0);
    check("rst_rresp", mem_rresp, 0);
    rst = 1'b0;
    tick();
    check("post_rst_awready", mem_awready, 1);
    check("post_rst_wready", mem_wready, 1);
    check("post_rst_arready", mem_arready, 1);

    // W before AW
    send_w(32'hDEAD_BEEF, 4'hF);
    check("w_buffer_full", mem_wready, 0);
    repeat (2) tick();
    check("no_b_without_aw", mem_bvalid, 0);
    send_aw(32'h8000_0010);
    get_b(OKAY);
    check("aw_free_after_b", mem_awready, 1);
    check("w_free_after_b", mem_wready, 1);
    read(32'h8000_0010, 32'hDEAD_BEEF, OKAY);

    // Partial strobe merge
    send_aww(32'h8000_0020, 32'h1122_3344, 4'hF);
    get_b(OKAY);
    send_aww(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    get_b(OKAY);
    read(32'h8000_0020, 32'h11BB_33DD, OKAY);
    send_aww(32'h8000_0030, 32'hCAFE_0030, 4'hF);
    get_b(OKAY);
    send_aww(32'h8000_0040, 32'h0BAD_0040, 4'hF);
    get_b(OKAY);

    // Back-to-back reads, rready high: rvalid every cycle from the third cycle
    mem_rready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        mem_arvalid = 1'b1; mem_araddr = a_tab[k];
        check($sformatf("b2b_arready%0d", k), mem_arready, 1);
      end else begin
        mem_arvalid = 1'b0;
      end
      if (k >= 2) begin
        check($sformatf("b2b_rvalid%0d", k), mem_rvalid, 1);
        check($sformatf("b2b_rdata%0d", k), mem_rdata, d_tab[k-2]);
        $display("R   b2b slot=%0d data=%h", k, mem_rdata);
      end else begin
        check($sformatf("b2b_rvalid%0d", k), mem_rvalid, 0);
      end
      tick();
    end
    check("b2b_drain", mem_rvalid, 0);
    mem_rready = 1'b0;

    // Backpressure: 4 accepts, then arready low; head stable for the hold
    for (int k = 0; k < 10; k++) begin
      mem_arvalid = 1'b1;
      mem_araddr  = (k < 4) ? a_tab[k] : 32'h8000_0050;
      check($sformatf("bp_arready%0d", k), mem_arready, (k < 4) ? 1'b1 : 1'b0);
      if (k >= 2) begin
        check($sformatf("bp_rvalid%0d", k), mem_rvalid, 1);
        check($sformatf("bp_rdata%0d", k), mem_rdata, d_tab[0]);
        check($sformatf("bp_rresp%0d", k), mem_rresp, OKAY);
      end
      tick();
    end
    mem_arvalid = 1'b0;
    mem_rready  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_rel_rvalid%0d", j), mem_rvalid, 1);
      check($sformatf("bp_rel_rdata%0d", j), mem_rdata, d_tab[j]);
      $display("R   release idx=%0d data=%h", j, mem_rdata);
      tick();
    end
    check("bp_empty", mem_rvalid, 0);
    check("bp_arready_back", mem_arready, 1);
    mem_rready = 1'b0;

    // Boundaries and decode errors
    send_aww(32'h8000_0000, 32'h0000_0A0A, 4'hF);
    get_b(OKAY);
    send_aww(32'h8000_0FFC, 32'h0FFC_0FFC, 4'hF);
    get_b(OKAY);
    read(32'h7FFF_FFFC, 32'h0000_0000, DECERR);
    send_aww(32'h8000_1000, 32'h5555_5555, 4'hF);
    get_b(DECERR);
    read(32'h8000_0000, 32'h0000_0A0A, OKAY);
    read(32'h8000_0FFC, 32'h0FFC_0FFC, OKAY);

    // Reset mid-operation: bvalid high and two reads outstanding
    send_aww(32'h8000_0060, 32'h1234_5678, 4'hF);
    n = 0;
    while (!mem_bvalid && n < TIMEOUT) begin tick(); n++; end
    check("pre_rst_bvalid", mem_bvalid, 1);
    mem_arvalid = 1'b1; mem_araddr = 32'h8000_0010;
    tick();
    mem_araddr = 32'h8000_0020;
    tick();
    mem_arvalid = 1'b0;
    tick();
    check("pre_rst_rvalid", mem_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bvalid", mem_bvalid, 0);
    check("mid_rst_rvalid", mem_rvalid, 0);
    check("mid_rst_rdata", mem_rdata, 0);
    check("mid_rst_bresp", mem_bresp, 0);
    check("mid_rst_arready", mem_arready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_awready", mem_awready, 1);
    check("rel_wready", mem_wready, 1);
    check("rel_arready", mem_arready, 1);
    mem_rready = 1'b1; mem_bready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("stale_rvalid%0d", k), mem_rvalid, 0);
      check($sformatf("stale_bvalid%0d", k), mem_bvalid, 0);
      tick();
    end
    mem_rready = 1'b0; mem_bready = 1'b0;
    read(32'h8000_0060, 32'h1234_5678, OKAY);
    read(32'h8000_0010, 32'hDEAD_BEEF, OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_mem_slave.md
AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, number of DATA_W-bit words stored.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter RD_LAT, default 2, read latency in cycles; legal range 1..15.
REQ-006 SHALL have parameter WR_LAT, default 1, write latency in cycles; legal range 0..15.
REQ-007 SHALL have parameter RD_DEPTH, default 4, maximum outstanding reads; power of two, at least 2.
REQ-008 SHALL use one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-009 SHALL have ports clk (in, 1, clock) and rst (in, 1, asynchronous active-high reset).
REQ-010 SHALL have AW ports: mem_awvalid (in, 1); mem_awready (out, 1); mem_awaddr (in, ADDR_W).
REQ-011 SHALL have W ports: mem_wvalid (in, 1); mem_wready (out, 1); mem_wdata (in, DATA_W); mem_wstrb (in, DATA_W/8).
REQ-012 SHALL have B ports: mem_bvalid (out, 1); mem_bready (in, 1); mem_bresp (out, 2).
REQ-013 SHALL have AR ports: mem_arvalid (in, 1); mem_arready (out, 1); mem_araddr (in, ADDR_W).
REQ-014 SHALL have R ports: mem_rvalid (out, 1); mem_rready (in, 1); mem_rdata (out, DATA_W); mem_rresp (out, 2).

Function
REQ-015 SHALL decode each address as word index = (addr - BASE_ADDR) >> log2(DATA_W/8), ignore the low byte bits, and treat addr < BASE_ADDR or index >= MEM_WORDS as out of range.
REQ-016 SHALL hold AW and W in independent one-entry buffers: mem_awready = AW buffer empty, mem_wready = W buffer empty, and accept either channel first or both in the same cycle.
REQ-017 SHALL run the write engine as W_IDLE -> W_WAIT (both buffers full) -> W_RESP (after WR_LAT cycles; with WR_LAT=0, W_RESP is entered on the cycle after both buffers fill) -> W_IDLE (on mem_bvalid && mem_bready).
REQ-018 SHALL, on entry to W_RESP, write every byte lane whose strobe is set for an in-range address, set mem_bresp=OKAY, and free both buffers.
REQ-019 SHALL, on entry to W_RESP for an out-of-range address, leave memory unchanged and set mem_bresp=DECERR.
REQ-020 SHALL assert mem_bvalid only in W_RESP and hold mem_bresp stable while mem_bvalid is high and mem_bready is low.
REQ-021 SHALL drive mem_arready = (outstanding reads < RD_DEPTH), with no combinational dependence on mem_rready.
REQ-022 SHALL, on AR accept, sample the memory word (0 if out of range) and the response (OKAY or DECERR), and push an entry with a latency counter of RD_LAT.
REQ-023 SHALL return read data as it stood at the AR accept cycle; a write committing in that same cycle is not visible to the read.
REQ-024 SHALL decrement every entry's counter each cycle, and raise mem_rvalid when the head entry's counter reaches 0, which gives a minimum AR-accept-to-rvalid latency of exactly RD_LAT cycles.
REQ-025 SHALL return read responses in order and hold mem_rdata and mem_rresp stable while mem_rvalid is high and mem_rready is low.
REQ-026 SHALL pop the head on mem_rvalid && mem_rready; a push and a pop in the same cycle leave the count unchanged.
REQ-027 SHALL sustain one read per cycle when RD_DEPTH >= RD_LAT+1 and mem_rready is held high.
REQ-028 SHALL keep the read and write paths fully independent; a busy write never stalls AR or R.

Reset
REQ-029 SHALL, on rst high, immediately clear all valid outputs, both write buffers, and the read queue; set mem_bresp, mem_rresp and mem_rdata to 0 and the write engine to W_IDLE.
REQ-030 SHALL drop any transaction in progress when rst asserts mid-operation; memory contents are not reset.
REQ-031 SHALL drive mem_awready, mem_wready and mem_arready high on the first clk edge after rst deasserts.

Structure
REQ-032 SHALL take from shared package axil_pkg the response codes OKAY=2'b00, SLVERR=2'b10 and DECERR=2'b11, plus the write-engine state enum (W_IDLE, W_WAIT, W_RESP).
REQ-033 SHALL implement the read queue as sub-module axil_rd_fifo, parameterised by width and RD_DEPTH, with synchronous push/pop, full/empty flags and an asynchronous active-high reset.

Verification
REQ-034 SHALL cover: W before AW (wdata 32'hDEAD_BEEF, strb 4'hF, AW to 0x8000_0010 three cycles later) -> one B with bresp OKAY; a later read of 0x8000_0010 -> rdata 32'hDEAD_BEEF.
REQ-035 SHALL cover: write 32'h1122_3344, then strb 4'b0101 with data 32'hAABB_CCDD to the same address -> read returns 32'h11BB_33DD.
REQ-036 SHALL cover: back-to-back ARs with rready held high, RD_LAT=2, RD_DEPTH=4 -> one rvalid per cycle from the third cycle, in issue order.
REQ-037 SHALL cover: rready held low for 10 cycles -> arready drops after 4 accepts and rdata/rresp stay stable; on release, all 4 responses are returned in order.
REQ-038 SHALL cover: read of 0x7FFF_FFFC and a write to BASE_ADDR+4*MEM_WORDS -> rresp DECERR with rdata 0, bresp DECERR, memory unchanged.
REQ-039 SHALL cover: rst asserted with 2 reads outstanding and bvalid high -> all valids low in the same cycle, and after release the ready outputs are high and no stale response appears.
